// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined register file.
package regfile_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefNRd     = 2;
  localparam int unsigned DefNWr     = 1;
  localparam int unsigned DefZeroReg = 1;
  localparam int unsigned DefBypass  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks a pointer over every register entry, one per cycle,
// whenever Reset or ClearReq starts a clear. Busy is high while it runs.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClearReq,
  output logic              Busy,
  output logic [ADDR_W-1:0] ClrPtr
);

  localparam logic [ADDR_W-1:0] LastPtr = '1;

  clrState_t state;

  // Sequencer state, pointer and registered Busy flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= CLEAR;
      ClrPtr <= '0;
      Busy   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (ClearReq) begin
            state  <= CLEAR;
            ClrPtr <= '0;
            Busy   <= 1'b1;
          end
        end
        CLEAR: begin
          if (ClearReq) begin
            ClrPtr <= '0;
          end else if (ClrPtr == LastPtr) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            ClrPtr <= ClrPtr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_reg_file.sv
// Multi-ported register file with registered reads, optional write-to-read
// forwarding, optional hard-wired zero register and a sequenced full clear.
module pipe_reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned N_RD     = DefNRd,
  parameter int unsigned N_WR     = DefNWr,
  parameter int unsigned ZERO_REG = DefZeroReg,
  parameter int unsigned BYPASS   = DefBypass
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ClearReq,
  input  logic [N_RD*ADDR_W-1:0]   RdAddr,
  output logic [N_RD*DATA_W-1:0]   RdData,
  input  logic [N_WR-1:0]          WrEn,
  input  logic [N_WR*ADDR_W-1:0]   WrAddr,
  input  logic [N_WR*DATA_W-1:0]   WrData,
  output logic                     Busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clrPtr;

  logic [ADDR_W-1:0] wAddr [N_WR];
  logic [DATA_W-1:0] wData [N_WR];
  logic [N_WR-1:0]   wrOk;
  logic [ADDR_W-1:0] rAddr [N_RD];
  logic [DATA_W-1:0] rdNext [N_RD];

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) uClearSeq (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .ClrPtr   (clrPtr)
  );

  // Unpack write ports and qualify each write (reset, clear, zero register).
  always_comb begin
    for (int unsigned p = 0; p < N_WR; p++) begin
      wAddr[p] = WrAddr[p*ADDR_W +: ADDR_W];
      wData[p] = WrData[p*DATA_W +: DATA_W];
      wrOk[p]  = WrEn[p] && !Reset && !Busy &&
                 !((ZERO_REG != 0) && (wAddr[p] == '0));
    end
  end

  // Array update: the clear write takes the slot while busy; otherwise higher
  // write ports are applied last so they win on an address collision.
  always_ff @(posedge Clk) begin
    if (Busy) begin
      mem[clrPtr] <= '0;
    end else begin
      for (int unsigned p = 0; p < N_WR; p++) begin
        if (wrOk[p]) begin
          mem[wAddr[p]] <= wData[p];
        end
      end
    end
  end

  // Next read value per port: array content, forwarded write data, zero register.
  always_comb begin
    for (int unsigned i = 0; i < N_RD; i++) begin
      rAddr[i]  = RdAddr[i*ADDR_W +: ADDR_W];
      rdNext[i] = mem[rAddr[i]];
      if (BYPASS != 0) begin
        for (int unsigned p = 0; p < N_WR; p++) begin
          if (wrOk[p] && (wAddr[p] == rAddr[i])) begin
            rdNext[i] = wData[p];
          end
        end
      end
      if ((ZERO_REG != 0) && (rAddr[i] == '0)) begin
        rdNext[i] = '0;
      end
    end
  end

  // Registered read outputs; forced to zero on reset and while clearing.
  always_ff @(posedge Clk) begin
    if (Reset || Busy) begin
      RdData <= '0;
    end else begin
      for (int unsigned i = 0; i < N_RD; i++) begin
        RdData[i*DATA_W +: DATA_W] <= rdNext[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Scoreboard bench for pipe_reg_file: directed scenarios plus random traffic,
// expectations from a behavioural model, compared by an independent monitor.
module tb_pipe_reg_file;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned N_RD     = 2;
  localparam int unsigned N_WR     = 2;
  localparam int unsigned ZERO_REG = 1;
  localparam int unsigned BYPASS   = 1;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic                   ClearReq;
  logic [N_RD*ADDR_W-1:0] RdAddr;
  logic [N_RD*DATA_W-1:0] RdData;
  logic [N_WR-1:0]        WrEn;
  logic [N_WR*ADDR_W-1:0] WrAddr;
  logic [N_WR*DATA_W-1:0] WrData;
  logic                   Busy;

  pipe_reg_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClearReq (ClearReq),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned            cyc;
    logic [N_RD*DATA_W-1:0] rd;
    logic                   busy;
  } exp_t;

  exp_t        expQ[$];
  int unsigned edgeCount = 0;
  int unsigned nChecks   = 0;
  int unsigned nPass     = 0;

  // Reference model state
  logic [DATA_W-1:0] mdl [DEPTH];
  int unsigned       clearLeft = 0;

  // Pending stimulus for the next cycle
  logic                   sRst, sClr;
  logic [N_WR-1:0]        sWe;
  logic [N_WR*ADDR_W-1:0] sWa;
  logic [N_WR*DATA_W-1:0] sWd;
  logic [N_RD*ADDR_W-1:0] sRa;

  always @(posedge Clk) edgeCount++;

  // Monitor: pops the expectation for the edge just taken and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (expQ.size() > 0 && expQ[0].cyc <= edgeCount) begin
        e = expQ.pop_front();
        nChecks++;
        if (e.cyc != edgeCount)
          $display("FAIL stale_entry cyc %0d: seen at edge %0d", e.cyc, edgeCount);
        else if (Busy !== e.busy)
          $display("FAIL busy cyc %0d: got %b want %b", e.cyc, Busy, e.busy);
        else
          nPass++;
        for (int i = 0; i < N_RD; i++) begin
          nChecks++;
          if (RdData[i*DATA_W +: DATA_W] !== e.rd[i*DATA_W +: DATA_W])
            $display("FAIL rddata port%0d cyc %0d: got %h want %h", i, e.cyc,
                     RdData[i*DATA_W +: DATA_W], e.rd[i*DATA_W +: DATA_W]);
          else
            nPass++;
        end
      end
    end
  end

  task automatic setW(input int p, input int unsigned a, input logic [DATA_W-1:0] d);
    sWe[p] = 1'b1;
    sWa[p*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
    sWd[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic setR(input int i, input int unsigned a);
    sRa[i*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
  endtask

  // Drive one cycle, predict its outcome, advance the model and the clock.
  task automatic step();
    exp_t        e;
    logic [DATA_W-1:0] v;
    int unsigned ra, wa;
    Reset    = sRst;
    ClearReq = sClr;
    WrEn     = sWe;
    WrAddr   = sWa;
    WrData   = sWd;
    RdAddr   = sRa;

    e.cyc = edgeCount + 1;
    e.rd  = '0;
    for (int i = 0; i < N_RD; i++) begin
      ra = int'(sRa[i*ADDR_W +: ADDR_W]);
      if (sRst || clearLeft > 0) begin
        v = '0;
      end else begin
        v = mdl[ra];
        if (BYPASS != 0)
          for (int p = 0; p < N_WR; p++) begin
            wa = int'(sWa[p*ADDR_W +: ADDR_W]);
            if (sWe[p] && wa == ra && !(ZERO_REG != 0 && wa == 0))
              v = sWd[p*DATA_W +: DATA_W];
          end
        if (ZERO_REG != 0 && ra == 0) v = '0;
      end
      e.rd[i*DATA_W +: DATA_W] = v;
    end

    // Clearing is invisible until it ends, so the model zeroes everything at once.
    if (sRst) begin
      for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
      clearLeft = DEPTH;
    end else if (clearLeft > 0) begin
      if (sClr) clearLeft = DEPTH;
      else clearLeft--;
    end else begin
      for (int p = 0; p < N_WR; p++) begin
        wa = int'(sWa[p*ADDR_W +: ADDR_W]);
        if (sWe[p] && !(ZERO_REG != 0 && wa == 0))
          mdl[wa] = sWd[p*DATA_W +: DATA_W];
      end
      if (sClr) begin
        for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
        clearLeft = DEPTH;
      end
    end
    e.busy = (clearLeft > 0);
    expQ.push_back(e);

    @(posedge Clk);
    #1;
    sRst = 1'b0;
    sClr = 1'b0;
    sWe  = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    sRst = 1'b1; sClr = 1'b0; sWe = '0; sWa = '0; sWd = '0; sRa = '0;

    // Reset, full clear window, then read back every register
    step();
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      setR(0, a);
      setR(1, DEPTH - 1 - a);
      step();
    end

    // Write then read on the next cycle
    setW(0, 5, 32'hDEADBEEF); step();
    setR(0, 5); step(); step();

    // Same-cycle write/read forwarding
    setW(0, 7, 32'h11111111); step();
    setW(0, 7, 32'h12345678); setR(0, 7); setR(1, 7); step();
    step();

    // Write-port collision, port 1 wins
    setW(0, 3, 32'hAAAA0000); setW(1, 3, 32'h5555FFFF); step();
    setR(0, 3); setR(1, 3); step(); step();

    // Zero register ignores writes and reads as zero, bypass included
    setW(0, 0, 32'hFFFFFFFF); setR(0, 0); step();
    step();

    // Clear interrupted by reset, writes blocked throughout
    setW(1, 31, 32'h1); step();
    setR(0, 31); step();
    sClr = 1'b1; step();
    for (int k = 0; k < 9; k++) begin
      setW(0, 31, $urandom); setW(1, $urandom_range(1, 31), $urandom); step();
    end
    sRst = 1'b1; step();
    for (int k = 0; k < DEPTH; k++) begin
      setW(0, 31, $urandom); setW(1, $urandom_range(1, 31), $urandom);
      setR(1, 31); step();
    end
    setR(0, 31); setR(1, 31); step(); step();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < N_WR; p++)
        if ($urandom_range(0, 1) == 1)
          setW(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                              : $urandom_range(0, 7), $urandom);
      for (int i = 0; i < N_RD; i++)
        setR(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                            : $urandom_range(0, 7));
      sClr = ($urandom_range(0, 199) == 0);
      sRst = ($urandom_range(0, 399) == 0);
      step();
    end
    idle(2);

    for (int k = 0; k < 4 && expQ.size() > 0; k++) @(negedge Clk);
    #1;
    if (expQ.size() != 0) begin
      nChecks++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
